dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 115 +++++++++++
 tb/tb_dma_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : dma_controller
// Purpose  : Single-channel device-to-memory DMA engine using a BR/BG bus
//            handshake; moves XFER_LEN 16-bit words per command.
// Revision : 1.0 - initial release
// ============================================================================
module dma_controller #(
   parameter int XFER_LEN = 12
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dma_start,
   input  logic [15:0] dma_addr,
   input  logic        BG,
   input  logic [15:0] dev_data,
   input  logic        mem_ack,
   output logic        BR,
   output logic [3:0]  dma_state,
   output logic [3:0]  dev_offset,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_write,
   output logic        dma_end
);

   localparam logic [3:0] c_LAST_IDX   = 4'(XFER_LEN - 1);
   localparam logic [3:0] c_STATE_CAP  = 4'd10;
   localparam logic [3:0] c_STATE_DONE = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [15:0] base_q,  base_d;

   logic        w_in_xfer;
   logic        w_beat;

   assign w_in_xfer = (state_q == S_XFER);
   // A word only counts when the bus is ours and memory took it this cycle.
   assign w_beat    = w_in_xfer & BG & mem_ack;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (dma_start) begin
               state_d = S_REQ;
               base_d  = dma_addr;
               cnt_d   = '0;
            end
         end
         S_REQ: begin
            if (BG) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (w_beat) begin
               if (cnt_q == c_LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

   // Outputs decode from registered state, so reset clears them at once.
   assign BR         = (state_q == S_REQ) | w_in_xfer;
   assign dma_end    = (state_q == S_DONE);
   assign mem_write  = w_in_xfer & BG;
   assign mem_addr   = w_in_xfer ? (base_q + {12'd0, cnt_q}) : 16'd0;
   assign mem_data   = w_in_xfer ? dev_data : 16'd0;
   assign dev_offset = w_in_xfer ? cnt_q : 4'd0;

   always_comb begin
      dma_state = 4'd0;
      if (w_in_xfer) begin
         dma_state = (cnt_q > c_STATE_CAP) ? c_STATE_CAP : cnt_q;
      end else if (state_q == S_DONE) begin
         dma_state = c_STATE_DONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_controller
// Purpose  : Directed self-checking bench for dma_controller with a
//            transfer-level reference model and per-scenario literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

   localparam int c_LEN = 12;

   logic        clk;
   logic        reset_n;
   logic        dma_start;
   logic [15:0] dma_addr;
   logic        BG;
   logic [15:0] dev_data;
   logic        mem_ack;
   logic        BR;
   logic [3:0]  dma_state;
   logic [3:0]  dev_offset;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_write;
   logic        dma_end;

   dma_controller #(.XFER_LEN(c_LEN)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dma_start  (dma_start),
      .dma_addr   (dma_addr),
      .BG         (BG),
      .dev_data   (dev_data),
      .mem_ack    (mem_ack),
      .BR         (BR),
      .dma_state  (dma_state),
      .dev_offset (dev_offset),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_write  (mem_write),
      .dma_end    (dma_end)
   );

   // Device buffer: word n holds 0xD000 + n*0x0101.
   assign dev_data = 16'hD000 + ({12'd0, dev_offset} * 16'h0101);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Scenario control from the stimulus process: 1 = clear stats, 2 = check.
   int cmd = 0;
   int exp_nwr, exp_first, exp_last, exp_span, exp_nend, exp_lastdata;
   int exp_lat, exp_wait, exp_pause;

   // Per-scenario measurements, owned by the compare process.
   int s_nwr, s_first, s_last, s_first_cyc, s_last_cyc, s_nend, s_lastdata;
   int s_grant_cyc, s_wait, s_pause;

   // Model: phase 0 idle, 1 awaiting grant, 2 moving words, 3 completion.
   int          m_phase = 0;
   int          m_words = 0;
   logic [15:0] m_base  = 16'd0;

   task automatic check(input string name, input longint act, input longint req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   always @(negedge clk) begin
      logic [42:0] act_v, exp_v;
      logic        e_br, e_end, e_wr;
      logic [3:0]  e_st, e_off;
      logic [15:0] e_addr, e_data;
      cyc++;

      if (!reset_n) begin
         m_phase = 0;
         m_words = 0;
         m_base  = 16'd0;
      end
      e_br   = (m_phase == 1) || (m_phase == 2);
      e_end  = (m_phase == 3);
      e_wr   = (m_phase == 2) && BG;
      e_st   = (m_phase == 2) ? 4'((m_words > 10) ? 10 : m_words) :
               (m_phase == 3) ? 4'd11 : 4'd0;
      e_off  = (m_phase == 2) ? 4'(m_words) : 4'd0;
      e_addr = (m_phase == 2) ? m_base + 16'(m_words) : 16'd0;
      e_data = (m_phase == 2) ? dev_data : 16'd0;
      exp_v  = {e_br, e_end, e_wr, e_st, e_off, e_addr, e_data};
      act_v  = {BR, dma_end, mem_write, dma_state, dev_offset, mem_addr, mem_data};
      check("outputs{BR,end,wr,state,off,addr,data}", act_v, exp_v);

      if (cmd == 1) begin
         s_nwr = 0; s_first = -1; s_last = -1; s_first_cyc = -1; s_last_cyc = -1;
         s_nend = 0; s_lastdata = -1; s_grant_cyc = -1; s_wait = 0; s_pause = 0;
      end else if (cmd == 2) begin
         check("word_count", s_nwr, exp_nwr);
         check("first_addr", s_first, exp_first);
         check("last_addr", s_last, exp_last);
         check("dma_end_count", s_nend, exp_nend);
         if (exp_span >= 0)     check("write_span_cycles", s_last_cyc - s_first_cyc + 1, exp_span);
         if (exp_lastdata >= 0) check("last_data", s_lastdata, exp_lastdata);
         if (exp_lat >= 0)      check("grant_to_first_write", s_first_cyc - s_grant_cyc, exp_lat);
         if (exp_wait >= 0)     check("request_wait_cycles", s_wait, exp_wait);
         if (exp_pause >= 0)    check("pause_cycles_state6", s_pause, exp_pause);
      end

      if (mem_write && mem_ack) begin
         if (s_nwr == 0) begin
            s_first     = int'(mem_addr);
            s_first_cyc = cyc;
         end
         s_nwr++;
         s_last     = int'(mem_addr);
         s_last_cyc = cyc;
         s_lastdata = int'(mem_data);
      end
      if (dma_end) s_nend++;
      if (BR && !mem_write && dma_state == 4'd0) s_wait++;
      if (BR && !mem_write && dma_state == 4'd6) s_pause++;

      // Advance the model to what must hold after the coming rising edge.
      if (reset_n) begin
         case (m_phase)
            0: if (dma_start) begin
                  m_phase = 1;
                  m_base  = dma_addr;
                  m_words = 0;
               end
            1: if (BG) begin
                  m_phase = 2;
                  if (s_grant_cyc < 0) s_grant_cyc = cyc;
               end
            2: if (BG && mem_ack) begin
                  if (m_words == c_LEN - 1) m_phase = 3;
                  else m_words++;
               end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] addr);
      dma_start = 1'b1;
      dma_addr  = addr;
      tick();
      dma_start = 1'b0;
      dma_addr  = 16'h0000;
   endtask

   task automatic scn_begin();
      cmd = 1;
      tick();
      cmd = 0;
   endtask

   task automatic scn_end(input int nwr, input int first, input int last, input int nend,
                          input int span, input int lastdata, input int lat,
                          input int wait_c, input int pause);
      exp_nwr = nwr; exp_first = first; exp_last = last; exp_nend = nend;
      exp_span = span; exp_lastdata = lastdata; exp_lat = lat;
      exp_wait = wait_c; exp_pause = pause;
      cmd = 2;
      tick();
      cmd = 0;
   endtask

   initial begin
      reset_n   = 1'b1;
      dma_start = 1'b0;
      dma_addr  = 16'h0000;
      BG        = 1'b0;
      mem_ack   = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Basic transfer, grant one cycle after the request.
      scn_begin();
      start(16'h01F0);
      tick();
      BG = 1'b1;
      repeat (20) tick();
      scn_end(12, 16'h01F0, 16'h01FB, 1, 12, 16'hDB0B, 1, 2, -1);

      // Grant withheld for 5 cycles.
      BG = 1'b0;
      scn_begin();
      start(16'h0300);
      repeat (5) tick();
      BG = 1'b1;
      repeat (20) tick();
      scn_end(12, 16'h0300, 16'h030B, 1, 12, 16'hDB0B, 1, 6, -1);

      // Memory stalls 3 cycles on word 4.
      scn_begin();
      start(16'h0400);
      tick();
      repeat (4) tick();
      mem_ack = 1'b0;
      repeat (3) tick();
      mem_ack = 1'b1;
      repeat (20) tick();
      scn_end(12, 16'h0400, 16'h040B, 1, 15, 16'hDB0B, 1, 1, -1);

      // Grant dropped for 4 cycles after six words.
      scn_begin();
      start(16'h0600);
      tick();
      repeat (6) tick();
      BG = 1'b0;
      repeat (4) tick();
      BG = 1'b1;
      repeat (20) tick();
      scn_end(12, 16'h0600, 16'h060B, 1, 16, 16'hDB0B, 1, 1, 4);

      // Address wrap through 0xFFFF.
      scn_begin();
      start(16'hFFFA);
      repeat (20) tick();
      scn_end(12, 16'hFFFA, 16'h0005, 1, 12, 16'hDB0B, 1, 1, -1);

      // Stray start mid-transfer, then reset at word 7.
      scn_begin();
      start(16'h1000);
      tick();
      repeat (3) tick();
      dma_start = 1'b1;
      dma_addr  = 16'h5555;
      tick();
      dma_start = 1'b0;
      dma_addr  = 16'h0000;
      repeat (3) tick();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      scn_end(7, 16'h1000, 16'h1006, 0, 7, 16'hD606, 1, 1, -1);

      // Fresh transfer after the reset uses the new base from word 0.
      scn_begin();
      start(16'h2000);
      repeat (20) tick();
      scn_end(12, 16'h2000, 16'h200B, 1, 12, 16'hDB0B, 1, 1, -1);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
